// File: rtl/uart_rx_sampler_if.sv
// Bundle of serial input, enable and receive-event outputs exchanged between
// the UART RX sampler (master) and the receive control FSM (slave).
interface uart_rx_sampler_if;
  logic i_rx;
  logic i_enable;
  logic o_zerodetected;
  logic o_bitvalid;
  logic o_bit;
  logic o_countreached;
  logic o_onedetected;
  logic o_framingerror;
  logic o_parityerror;
  logic o_busy;

  modport master (
    input  i_rx, i_enable,
    output o_zerodetected, o_bitvalid, o_bit, o_countreached,
           o_onedetected, o_framingerror, o_parityerror, o_busy
  );

  modport slave (
    output i_rx, i_enable,
    input  o_zerodetected, o_bitvalid, o_bit, o_countreached,
           o_onedetected, o_framingerror, o_parityerror, o_busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises the serial line, oversamples 16x and
// majority-votes each bit, emitting registered frame events for the RX FSM.
module uart_rx_sampler #(
  parameter int DIV        = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  uart_rx_sampler_if.master   rx_bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s, rx_prev, armed;
  logic [1:0]    sync_fill;
  logic [PW-1:0] presc;
  logic [3:0]    s;
  logic          v7, v8;
  logic [3:0]    bitcnt, bitcnt_next;
  logic          parity, parity_next;
  logic          tick, vote_evt, vote, fall;

  logic zd_q, bv_q, bit_q, cr_q, od_q, fe_q, pe_q;
  logic zd_n, bv_n, bit_n, cr_n, od_n, fe_n, pe_n;

  assign tick     = (state != IDLE) && (presc == PW'(DIV - 1));
  assign vote_evt = tick && (s == 4'd9);
  assign vote     = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);
  assign fall     = armed && rx_prev && !rx_s;

  // A start needs a genuine high-to-low edge, so the edge detector stays
  // disarmed until the synchroniser has delivered a real high sample.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rx_bus.i_rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_s)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc <= '0;
      s     <= 4'd0;
      v7    <= 1'b0;
      v8    <= 1'b0;
    end else if (state == IDLE) begin
      presc <= '0;
      s     <= 4'd0;
    end else if (tick) begin
      presc <= '0;
      s     <= s + 4'd1;
      if (s == 4'd7) v7 <= rx_s;
      if (s == 4'd8) v8 <= rx_s;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      bitcnt <= 4'd0;
      parity <= 1'b0;
      zd_q   <= 1'b0;
      bv_q   <= 1'b0;
      bit_q  <= 1'b0;
      cr_q   <= 1'b0;
      od_q   <= 1'b0;
      fe_q   <= 1'b0;
      pe_q   <= 1'b0;
    end else begin
      state  <= state_next;
      bitcnt <= bitcnt_next;
      parity <= parity_next;
      zd_q   <= zd_n;
      bv_q   <= bv_n;
      bit_q  <= bit_n;
      cr_q   <= cr_n;
      od_q   <= od_n;
      fe_q   <= fe_n;
      pe_q   <= pe_n;
    end
  end

  // Every event is decided on the s==9 tick and registered, so pulses appear
  // one clock later; dropping enable overrides everything and idles the FSM.
  always_comb begin
    state_next  = state;
    bitcnt_next = bitcnt;
    parity_next = parity;
    zd_n        = 1'b0;
    bv_n        = 1'b0;
    bit_n       = bit_q;
    cr_n        = 1'b0;
    od_n        = 1'b0;
    fe_n        = 1'b0;
    pe_n        = pe_q;
    if (!rx_bus.i_enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state_next  = START;
            bitcnt_next = 4'd0;
            parity_next = 1'b0;
            pe_n        = 1'b0;
          end
        end
        START: begin
          if (vote_evt) begin
            if (!vote) begin
              state_next  = DATA;
              zd_n        = 1'b1;
              bitcnt_next = 4'd0;
            end else begin
              state_next = IDLE;
            end
          end
        end
        DATA: begin
          if (vote_evt) begin
            bv_n        = 1'b1;
            bit_n       = vote;
            parity_next = parity ^ vote;
            bitcnt_next = bitcnt + 4'd1;
            if (bitcnt == 4'(DATA_BITS - 1)) begin
              cr_n       = 1'b1;
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (vote_evt) begin
            pe_n       = parity ^ vote ^ (PARITY_ODD != 0);
            state_next = STOP;
          end
        end
        STOP: begin
          if (vote_evt) begin
            od_n       = vote;
            fe_n       = !vote;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign rx_bus.o_zerodetected = zd_q;
  assign rx_bus.o_bitvalid     = bv_q;
  assign rx_bus.o_bit          = bit_q;
  assign rx_bus.o_countreached = cr_q;
  assign rx_bus.o_onedetected  = od_q;
  assign rx_bus.o_framingerror = fe_q;
  assign rx_bus.o_parityerror  = pe_q;
  assign rx_bus.o_busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: directed frames push expected events,
// a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_uart_rx_sampler;

  localparam int DIV      = 4;
  localparam int BIT_CLKS = 16 * DIV;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_sampler_if bus();

  uart_rx_sampler #(
    .DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .rx_bus (bus.master)
  );

  always #5 clk = ~clk;

  // Event vector: {zd, bitvalid, bit, countreached, onedet, framerr, parerr, busy}
  logic [7:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  function automatic logic [7:0] sampleOutputs();
    return {bus.o_zerodetected, bus.o_bitvalid, bus.o_bit, bus.o_countreached,
            bus.o_onedetected, bus.o_framingerror, bus.o_parityerror, bus.o_busy};
  endfunction

  always @(negedge clk) begin
    logic [7:0] act;
    logic [7:0] expv;
    act = sampleOutputs();
    if (act[7] | act[6] | act[3] | act[2]) begin
      if (!act[6]) act[5] = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_event at %0t: got %b, expected none", $time, act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          fails++;
          $display("[TB] FAIL event at %0t: got %b, expected %b", $time, act, expv);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] expv, input logic [7:0] mask);
    logic [7:0] act;
    act = sampleOutputs() & mask;
    checks++;
    if (act !== (expv & mask)) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, expv & mask);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_rx = 1'b1;
    end
  endtask

  // abort_kind: 0 none, 1 reset pulse, 2 enable drop; both 10 clocks into
  // data bit abort_d. After a reset the sender abandons the frame once bit 7 starts.
  task automatic applyStimulus(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                               input int glitch_d, input int abort_kind, input int abort_d);
    int    ab_t;
    int    n_bits;
    int    b;
    logic  pe_exp;
    logic  v;
    ab_t   = (abort_kind != 0) ? (abort_d + 1) * BIT_CLKS + 10 : -10;
    n_bits = (abort_kind != 0) ? abort_d : 8;
    pe_exp = par_bit ^ (^data);
    exp_q.push_back(8'b1000_0001);
    for (int d = 0; d < n_bits; d++)
      exp_q.push_back({2'b01, data[d], (d == 7), 3'b000, 1'b1});
    if (abort_kind == 0)
      exp_q.push_back({4'b0000, stop_bit, !stop_bit, pe_exp, 1'b0});
    for (int t = 0; t < 11 * BIT_CLKS; t++) begin
      @(negedge clk);
      b = t / BIT_CLKS;
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = data[b-1];
      else if (b == 9) v = par_bit;
      else             v = stop_bit;
      if (glitch_d >= 0 && b == glitch_d + 1 && (t % BIT_CLKS) >= 34 && (t % BIT_CLKS) <= 37)
        v = 1'b1;
      if (abort_kind == 1 && t > ab_t && b >= 8)
        v = 1'b1;
      bus.i_rx = v;
      if (t == ab_t) begin
        if (abort_kind == 1) reset = 1'b1;
        else                 bus.i_enable = 1'b0;
      end
      if (t == ab_t + 1) begin
        reset = 1'b0;
        if (abort_kind == 1) checkOutput("reset_mid_frame", 8'h00, 8'hFF);
        else                 checkOutput("enable_low_mid_frame", 8'h00, 8'b1101_1101);
      end
    end
  endtask

  initial begin
    bus.i_rx     = 1'b1;
    bus.i_enable = 1'b1;
    reset        = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_state", 8'h00, 8'hFF);
    reset = 1'b0;
    idle(20);

    // Clean even-parity frame
    applyStimulus(8'h55, 1'b0, 1'b1, -1, 0, 0);
    idle(20);

    // Short low pulse: false start, then a normal frame
    repeat (12) begin
      @(negedge clk);
      bus.i_rx = 1'b0;
    end
    idle(80);
    checkOutput("false_start_idle", 8'h00, 8'hDF);
    applyStimulus(8'h3C, 1'b0, 1'b1, -1, 0, 0);
    idle(20);

    // Wrong parity bit: error level holds until the next start clears it
    applyStimulus(8'hA5, 1'b1, 1'b1, -1, 0, 0);
    idle(20);
    checkOutput("parity_error_held", 8'b0000_0010, 8'hDF);
    applyStimulus(8'h0F, 1'b0, 1'b1, -1, 0, 0);
    idle(20);
    checkOutput("parity_error_cleared", 8'h00, 8'hDF);

    // Stop bit low, then recovery
    applyStimulus(8'hFF, 1'b0, 1'b0, -1, 0, 0);
    idle(20);
    applyStimulus(8'h01, 1'b1, 1'b1, -1, 0, 0);
    idle(20);

    // Reset during data bit 4, then the same byte again
    applyStimulus(8'h81, 1'b0, 1'b1, -1, 1, 4);
    idle(20);
    applyStimulus(8'h81, 1'b0, 1'b1, -1, 0, 0);
    idle(20);

    // Glitch on data bit 2 outvoted, then enable dropped in data bit 5
    applyStimulus(8'h00, 1'b0, 1'b1, 2, 2, 5);
    idle(20);
    bus.i_enable = 1'b1;
    idle(40);
    checkOutput("idle_after_enable", 8'h00, 8'hDF);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
